// File: rtl/gmac_tx_feeder.sv
// ---------------------------------------------------------------------------
// gmac_tx_feeder
//
// Single-frame transmit feeder for one GMAC input channel. User bytes are
// collected into an internal buffer. Once a frame is complete, a transmit
// request is raised towards the MAC. After the MAC grants it, the frame is
// streamed out contiguously with SOF/EOF framing. An idle gap follows before
// the next frame is accepted.
//
// Ports:
//   CLK, RST_N         clock, synchronous active-low reset
//   WR_VAL/DATA/LAST   user byte stream in
//   WR_READY           feeder accepts user bytes (FILL and DISCARD)
//   REQ_OUT            transmit request to the MAC (ReqInN)
//   CONFIRM_IN         MAC grant (ReqConfirm[N]); only looked at in REQ
//   VAL/SOF/EOF/DATA   registered frame stream to the MAC
//   BUSY               high in every state except FILL
//   DROP               one-cycle pulse when an oversize frame is discarded
//   FRAME_CNT          frames sent, wrapping 16-bit counter
// ---------------------------------------------------------------------------
module gmac_tx_feeder #(
    parameter int ADDR_W     = 11,
    parameter int MAX_LEN    = 1472,
    parameter int GAP_CYCLES = 12
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        WR_VAL,
    input  logic [7:0]  WR_DATA,
    input  logic        WR_LAST,
    output logic        WR_READY,
    output logic        REQ_OUT,
    input  logic        CONFIRM_IN,
    output logic        VAL_OUT,
    output logic        SOF_OUT,
    output logic        EOF_OUT,
    output logic [7:0]  DATA_OUT,
    output logic        BUSY,
    output logic        DROP,
    output logic [15:0] FRAME_CNT
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int LEN_W = ADDR_W + 1;
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);

    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
    localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_CYCLES);

    typedef enum logic [2:0] {
        ST_FILL,
        ST_DISCARD,
        ST_REQ,
        ST_SEND,
        ST_GAP
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
    logic [15:0]       frame_cnt_q, frame_cnt_d;
    logic              req_q, req_d;
    logic              val_q, val_d;
    logic              sof_q, sof_d;
    logic              eof_q, eof_d;
    logic              drop_q, drop_d;
    logic [7:0]        data_q;

    logic              mem_we;
    logic              rd_en;
    logic              last_rd;

    logic [7:0]        mem [DEPTH];

    // The byte being read in this SEND cycle is the final one of the frame.
    assign last_rd = ({1'b0, rd_ptr_q} == (len_q - LEN_W'(1)));

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        len_d       = len_q;
        gap_cnt_d   = gap_cnt_q;
        frame_cnt_d = frame_cnt_q;
        req_d       = 1'b0;
        val_d       = 1'b0;
        sof_d       = 1'b0;
        eof_d       = 1'b0;
        drop_d      = 1'b0;
        mem_we      = 1'b0;
        rd_en       = 1'b0;

        case (state_q)
            ST_FILL: begin
                if (WR_VAL) begin
                    if (len_q == MAX_LEN_L) begin
                        // Buffer already holds a full frame: this byte is
                        // one too many. A LAST here ends the bad frame
                        // immediately; otherwise swallow the rest in DISCARD.
                        drop_d   = 1'b1;
                        len_d    = '0;
                        wr_ptr_d = '0;
                        state_d  = WR_LAST ? ST_FILL : ST_DISCARD;
                    end else begin
                        mem_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + 1'b1;
                        len_d    = len_q + 1'b1;
                        if (WR_LAST) begin
                            state_d = ST_REQ;
                            req_d   = 1'b1;
                        end
                    end
                end
            end

            ST_DISCARD: begin
                if (WR_VAL && WR_LAST) begin
                    state_d = ST_FILL;
                end
            end

            ST_REQ: begin
                if (CONFIRM_IN) begin
                    state_d  = ST_SEND;
                    rd_ptr_d = '0;
                end else begin
                    req_d = 1'b1;
                end
            end

            ST_SEND: begin
                // Outputs computed here appear one cycle later together
                // with the registered RAM read of rd_ptr_q.
                rd_en    = 1'b1;
                val_d    = 1'b1;
                sof_d    = (rd_ptr_q == '0);
                eof_d    = last_rd;
                rd_ptr_d = rd_ptr_q + 1'b1;
                if (last_rd) begin
                    state_d     = ST_GAP;
                    len_d       = '0;
                    wr_ptr_d    = '0;
                    rd_ptr_d    = '0;
                    gap_cnt_d   = '0;
                    frame_cnt_d = frame_cnt_q + 1'b1;
                end
            end

            ST_GAP: begin
                // GAP is entered in the same cycle the EOF byte is shown,
                // so counting to GAP_CYCLES inclusive leaves GAP_CYCLES
                // idle cycles after EOF.
                if (gap_cnt_q == GAP_LAST) begin
                    state_d   = ST_FILL;
                    gap_cnt_d = '0;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = ST_FILL;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q     <= ST_FILL;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            len_q       <= '0;
            gap_cnt_q   <= '0;
            frame_cnt_q <= '0;
            req_q       <= 1'b0;
            val_q       <= 1'b0;
            sof_q       <= 1'b0;
            eof_q       <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            len_q       <= len_d;
            gap_cnt_q   <= gap_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            req_q       <= req_d;
            val_q       <= val_d;
            sof_q       <= sof_d;
            eof_q       <= eof_d;
            drop_q      <= drop_d;
        end
    end

    // Frame buffer storage; contents deliberately survive reset.
    always_ff @(posedge CLK) begin
        if (mem_we && RST_N) begin
            mem[wr_ptr_q] <= WR_DATA;
        end
    end

    // Registered read port. Cleared when not sending so DATA_OUT is 0
    // whenever VAL_OUT is low.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            data_q <= '0;
        end else if (rd_en) begin
            data_q <= mem[rd_ptr_q];
        end else begin
            data_q <= '0;
        end
    end

    assign WR_READY  = (state_q == ST_FILL) || (state_q == ST_DISCARD);
    assign BUSY      = (state_q != ST_FILL);
    assign REQ_OUT   = req_q;
    assign VAL_OUT   = val_q;
    assign SOF_OUT   = sof_q;
    assign EOF_OUT   = eof_q;
    assign DATA_OUT  = data_q;
    assign DROP      = drop_q;
    assign FRAME_CNT = frame_cnt_q;

endmodule

// File: tb/tb_gmac_tx_feeder.sv
// ---------------------------------------------------------------------------
// tb_gmac_tx_feeder
//
// Self-checking bench for gmac_tx_feeder. A cycle table covers reset, a
// 4-byte frame, a 1-byte frame and grant toggles outside REQ. Hand-written
// sequences cover oversize drops, a maximum-length frame, a long grant
// delay and a reset in the middle of a frame.
// ---------------------------------------------------------------------------
module tb_gmac_tx_feeder;

    localparam int ADDR_W     = 11;
    localparam int MAX_LEN    = 1472;
    localparam int GAP_CYCLES = 12;
    localparam int NUM_VECS   = 29;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        WR_VAL;
    logic [7:0]  WR_DATA;
    logic        WR_LAST;
    logic        WR_READY;
    logic        REQ_OUT;
    logic        CONFIRM_IN;
    logic        VAL_OUT;
    logic        SOF_OUT;
    logic        EOF_OUT;
    logic [7:0]  DATA_OUT;
    logic        BUSY;
    logic        DROP;
    logic [15:0] FRAME_CNT;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  frame_q[$];

    typedef struct packed {
        logic        rst_n;
        logic        wr_val;
        logic [7:0]  wr_data;
        logic        wr_last;
        logic        confirm;
        logic        e_ready;
        logic        e_req;
        logic        e_val;
        logic        e_sof;
        logic        e_eof;
        logic [7:0]  e_data;
        logic        e_busy;
        logic        e_drop;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vecs [NUM_VECS];

    gmac_tx_feeder #(
        .ADDR_W    (ADDR_W),
        .MAX_LEN   (MAX_LEN),
        .GAP_CYCLES(GAP_CYCLES)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .WR_VAL    (WR_VAL),
        .WR_DATA   (WR_DATA),
        .WR_LAST   (WR_LAST),
        .WR_READY  (WR_READY),
        .REQ_OUT   (REQ_OUT),
        .CONFIRM_IN(CONFIRM_IN),
        .VAL_OUT   (VAL_OUT),
        .SOF_OUT   (SOF_OUT),
        .EOF_OUT   (EOF_OUT),
        .DATA_OUT  (DATA_OUT),
        .BUSY      (BUSY),
        .DROP      (DROP),
        .FRAME_CNT (FRAME_CNT)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: actual timeout required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mk(input logic r, wv, input logic [7:0] wd,
                                input logic wl, cf, er, eq, ev, es, ee,
                                input logic [7:0] ed, input logic eb, edr,
                                input logic [15:0] ec);
        vec_t v;
        v.rst_n   = r;
        v.wr_val  = wv;
        v.wr_data = wd;
        v.wr_last = wl;
        v.confirm = cf;
        v.e_ready = er;
        v.e_req   = eq;
        v.e_val   = ev;
        v.e_sof   = es;
        v.e_eof   = ee;
        v.e_data  = ed;
        v.e_busy  = eb;
        v.e_drop  = edr;
        v.e_cnt   = ec;
        return v;
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        WR_VAL     = 1'b0;
        WR_DATA    = 8'h00;
        WR_LAST    = 1'b0;
        CONFIRM_IN = 1'b0;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        RST_N      = v.rst_n;
        WR_VAL     = v.wr_val;
        WR_DATA    = v.wr_data;
        WR_LAST    = v.wr_last;
        CONFIRM_IN = v.confirm;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (!(WR_READY && !BUSY) && n < 100) begin
            step();
            n++;
        end
        checkOutput({name, "_idle_timeout"}, (n < 100), 1);
    endtask

    // Writes frame_q with LAST on the final byte; ends just after commit.
    task automatic write_frame();
        int drops = 0;
        int rdy_low = 0;
        foreach (frame_q[i]) begin
            if (!WR_READY) rdy_low++;
            WR_VAL  = 1'b1;
            WR_DATA = frame_q[i];
            WR_LAST = (i == frame_q.size() - 1);
            step();
            if (DROP) drops++;
        end
        idle_inputs();
        checkOutput("wr_ready_in_fill", rdy_low, 0);
        checkOutput("wr_no_drop", drops, 0);
        checkOutput("wr_ready_after_commit", WR_READY, 0);
        checkOutput("wr_req_after_commit", REQ_OUT, 1);
    endtask

    // Grants after grant_delay cycles and checks the outgoing stream,
    // the frame counter and the idle gap.
    task automatic send_frame(input int grant_delay, input logic [15:0] exp_cnt,
                              input logic toggle_gap);
        int req_lost = 0;
        int val_early = 0;
        int gap_ready = 0;
        int gap_val = 0;
        int gap_req = 0;
        for (int k = 0; k < grant_delay; k++) begin
            step();
            if (!REQ_OUT) req_lost++;
            if (VAL_OUT) val_early++;
        end
        checkOutput("req_held", req_lost, 0);
        checkOutput("no_val_in_req", val_early, 0);
        CONFIRM_IN = 1'b1;
        step();
        CONFIRM_IN = 1'b0;
        checkOutput("req_clear_after_grant", REQ_OUT, 0);
        checkOutput("val_read_latency", VAL_OUT, 0);
        step();
        for (int i = 0; i < frame_q.size(); i++) begin
            checkOutput($sformatf("byte%0d_val", i), VAL_OUT, 1);
            checkOutput($sformatf("byte%0d_sof", i), SOF_OUT, (i == 0));
            checkOutput($sformatf("byte%0d_eof", i), EOF_OUT, (i == frame_q.size() - 1));
            checkOutput($sformatf("byte%0d_data", i), DATA_OUT, frame_q[i]);
            if (i != frame_q.size() - 1) step();
        end
        checkOutput("frame_cnt", FRAME_CNT, exp_cnt);
        checkOutput("ready_at_eof", WR_READY, 0);
        for (int g = 1; g <= GAP_CYCLES; g++) begin
            CONFIRM_IN = toggle_gap && g[0];
            step();
            if (WR_READY) gap_ready++;
            if (VAL_OUT) gap_val++;
            if (REQ_OUT) gap_req++;
        end
        CONFIRM_IN = 1'b0;
        checkOutput("gap_ready_low", gap_ready, 0);
        checkOutput("gap_no_val", gap_val, 0);
        checkOutput("gap_no_req", gap_req, 0);
        step();
        checkOutput("ready_after_gap", WR_READY, 1);
        checkOutput("busy_after_gap", BUSY, 0);
        checkOutput("cnt_after_gap", FRAME_CNT, exp_cnt);
    endtask

    initial begin
        int bad;
        int drops;
        int reqs;
        int vals;

        idle_inputs();
        RST_N = 1'b0;

        // Cycle table: inputs before an edge, expected outputs after it.
        vecs[0]  = mk(0, 0, 8'h00, 0, 0, 1, 0, 0, 0, 0, 8'h00, 0, 0, 16'd0);
        vecs[1]  = mk(1, 1, 8'h11, 0, 1, 1, 0, 0, 0, 0, 8'h00, 0, 0, 16'd0);
        vecs[2]  = mk(1, 1, 8'h22, 0, 0, 1, 0, 0, 0, 0, 8'h00, 0, 0, 16'd0);
        vecs[3]  = mk(1, 1, 8'h33, 0, 1, 1, 0, 0, 0, 0, 8'h00, 0, 0, 16'd0);
        vecs[4]  = mk(1, 1, 8'h44, 1, 0, 0, 1, 0, 0, 0, 8'h00, 1, 0, 16'd0);
        vecs[5]  = mk(1, 0, 8'h00, 0, 0, 0, 1, 0, 0, 0, 8'h00, 1, 0, 16'd0);
        vecs[6]  = mk(1, 0, 8'h00, 0, 0, 0, 1, 0, 0, 0, 8'h00, 1, 0, 16'd0);
        vecs[7]  = mk(1, 0, 8'h00, 0, 1, 0, 0, 0, 0, 0, 8'h00, 1, 0, 16'd0);
        vecs[8]  = mk(1, 0, 8'h00, 0, 0, 0, 0, 1, 1, 0, 8'h11, 1, 0, 16'd0);
        vecs[9]  = mk(1, 0, 8'h00, 0, 0, 0, 0, 1, 0, 0, 8'h22, 1, 0, 16'd0);
        vecs[10] = mk(1, 0, 8'h00, 0, 0, 0, 0, 1, 0, 0, 8'h33, 1, 0, 16'd0);
        vecs[11] = mk(1, 0, 8'h00, 0, 0, 0, 0, 1, 0, 1, 8'h44, 1, 0, 16'd1);
        for (int k = 12; k <= 23; k++) begin
            vecs[k] = mk(1, 0, 8'h00, 0, k[0], 0, 0, 0, 0, 0, 8'h00, 1, 0, 16'd1);
        end
        vecs[24] = mk(1, 0, 8'h00, 0, 0, 1, 0, 0, 0, 0, 8'h00, 0, 0, 16'd1);
        vecs[25] = mk(1, 1, 8'hA5, 1, 0, 0, 1, 0, 0, 0, 8'h00, 1, 0, 16'd1);
        vecs[26] = mk(1, 0, 8'h00, 0, 1, 0, 0, 0, 0, 0, 8'h00, 1, 0, 16'd1);
        vecs[27] = mk(1, 0, 8'h00, 0, 0, 0, 0, 1, 1, 1, 8'hA5, 1, 0, 16'd2);
        vecs[28] = mk(1, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 8'h00, 1, 0, 16'd2);

        for (int i = 0; i < NUM_VECS; i++) begin
            applyStimulus(vecs[i]);
            step();
            checkOutput($sformatf("v%0d_ready", i), WR_READY, vecs[i].e_ready);
            checkOutput($sformatf("v%0d_req", i), REQ_OUT, vecs[i].e_req);
            checkOutput($sformatf("v%0d_val", i), VAL_OUT, vecs[i].e_val);
            checkOutput($sformatf("v%0d_sof", i), SOF_OUT, vecs[i].e_sof);
            checkOutput($sformatf("v%0d_eof", i), EOF_OUT, vecs[i].e_eof);
            checkOutput($sformatf("v%0d_data", i), DATA_OUT, vecs[i].e_data);
            checkOutput($sformatf("v%0d_busy", i), BUSY, vecs[i].e_busy);
            checkOutput($sformatf("v%0d_drop", i), DROP, vecs[i].e_drop);
            checkOutput($sformatf("v%0d_cnt", i), FRAME_CNT, vecs[i].e_cnt);
        end
        idle_inputs();
        wait_idle("table");

        // Oversize: MAX_LEN bytes without LAST, one more drops, then
        // ten bytes ending in LAST are swallowed.
        bad = 0;
        for (int i = 0; i < MAX_LEN; i++) begin
            WR_VAL  = 1'b1;
            WR_DATA = i[7:0];
            WR_LAST = 1'b0;
            step();
            if (DROP || REQ_OUT) bad++;
        end
        checkOutput("ovs_prefix_clean", bad, 0);
        WR_DATA = 8'hEE;
        step();
        checkOutput("ovs_drop", DROP, 1);
        checkOutput("ovs_busy_discard", BUSY, 1);
        checkOutput("ovs_ready_discard", WR_READY, 1);
        checkOutput("ovs_no_req", REQ_OUT, 0);
        drops = 0;
        reqs  = 0;
        for (int j = 0; j < 10; j++) begin
            WR_VAL  = 1'b1;
            WR_DATA = j[7:0];
            WR_LAST = (j == 9);
            step();
            if (DROP) drops++;
            if (REQ_OUT || VAL_OUT) reqs++;
        end
        idle_inputs();
        checkOutput("ovs_single_drop", drops, 0);
        checkOutput("ovs_no_req_tail", reqs, 0);
        checkOutput("ovs_back_to_fill", BUSY, 0);
        checkOutput("ovs_cnt", FRAME_CNT, 2);
        frame_q = '{8'hDE, 8'hAD};
        write_frame();
        send_frame(0, 16'd3, 1'b0);

        // Oversize where the extra byte carries LAST: straight back to FILL.
        bad = 0;
        for (int i = 0; i < MAX_LEN; i++) begin
            WR_VAL  = 1'b1;
            WR_DATA = i[7:0];
            WR_LAST = 1'b0;
            step();
            if (DROP || REQ_OUT) bad++;
        end
        checkOutput("ovl_prefix_clean", bad, 0);
        WR_LAST = 1'b1;
        step();
        checkOutput("ovl_drop", DROP, 1);
        checkOutput("ovl_busy", BUSY, 0);
        checkOutput("ovl_ready", WR_READY, 1);
        idle_inputs();
        step();
        checkOutput("ovl_drop_pulse", DROP, 0);
        checkOutput("ovl_no_req", REQ_OUT, 0);
        checkOutput("ovl_cnt", FRAME_CNT, 3);

        // Maximum-length frame with an incrementing pattern.
        frame_q = {};
        for (int i = 0; i < MAX_LEN; i++) frame_q.push_back(i[7:0]);
        write_frame();
        send_frame(2, 16'd4, 1'b0);

        // Grant toggles in FILL, a long-delayed grant, toggles in GAP.
        bad = 0;
        for (int k = 0; k < 6; k++) begin
            CONFIRM_IN = k[0];
            step();
            if (REQ_OUT || VAL_OUT || BUSY) bad++;
        end
        CONFIRM_IN = 1'b0;
        checkOutput("fill_confirm_ignored", bad, 0);
        frame_q = '{8'h5A, 8'hC3, 8'h0F};
        write_frame();
        send_frame(1000, 16'd5, 1'b1);
        bad = 0;
        for (int k = 0; k < 6; k++) begin
            CONFIRM_IN = ~k[0];
            step();
            if (REQ_OUT || VAL_OUT) bad++;
        end
        CONFIRM_IN = 1'b0;
        checkOutput("post_gap_confirm_ignored", bad, 0);
        checkOutput("delayed_one_frame", FRAME_CNT, 5);

        // Reset while byte 5 of a 20-byte frame would be shown.
        frame_q = {};
        for (int i = 0; i < 20; i++) frame_q.push_back(8'h40 + i[7:0]);
        write_frame();
        CONFIRM_IN = 1'b1;
        step();
        CONFIRM_IN = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("rst_byte%0d_val", i), VAL_OUT, 1);
            checkOutput($sformatf("rst_byte%0d_data", i), DATA_OUT, frame_q[i]);
            if (i != 4) step();
        end
        RST_N = 1'b0;
        step();
        checkOutput("rst_val", VAL_OUT, 0);
        checkOutput("rst_sof", SOF_OUT, 0);
        checkOutput("rst_eof", EOF_OUT, 0);
        checkOutput("rst_data", DATA_OUT, 0);
        checkOutput("rst_req", REQ_OUT, 0);
        checkOutput("rst_drop", DROP, 0);
        checkOutput("rst_ready", WR_READY, 1);
        checkOutput("rst_busy", BUSY, 0);
        checkOutput("rst_cnt", FRAME_CNT, 0);
        RST_N = 1'b1;
        vals = 0;
        for (int k = 0; k < 25; k++) begin
            step();
            if (VAL_OUT || EOF_OUT) vals++;
        end
        checkOutput("rst_no_tail", vals, 0);
        frame_q = '{8'h01, 8'h02, 8'h03};
        write_frame();
        send_frame(1, 16'd1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
